pipe_reg: RTL and testbench

PIPE_REG -- requirements
Module: pipe_reg

---
 rtl/pipe_stage.sv | 51 +++++
 rtl/pipe_reg.sv | 95 +++++++++
 tb/tb_pipe_reg.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage.sv
// One pipeline slot: a valid flag and a data word. Data loads only on an accepted
// transfer into this slot; a flush empties the slot but leaves its data untouched.
module pipe_stage #(
    parameter int WIDTH = 6
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             up_vld_i,
    input  logic [WIDTH-1:0] up_dat_i,
    input  logic             rdy_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] dat_o
);

    logic             vld_q;
    logic             vld_d;
    logic [WIDTH-1:0] dat_q;
    logic [WIDTH-1:0] dat_d;
    logic             load;

    // rdy_i high means this slot is empty or drains this cycle, so it takes whatever
    // the sender offers (possibly nothing).
    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        load  = up_vld_i & rdy_i & ~flush_i;
        if (flush_i) begin
            vld_d = 1'b0;
        end else if (rdy_i) begin
            vld_d = up_vld_i;
        end
        if (load) begin
            dat_d = up_dat_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign vld_o = vld_q;
    assign dat_o = dat_q;

endmodule

// File: rtl/pipe_reg.sv
// DEPTH-stage valid/ready register pipeline with a combinational ready chain,
// synchronous flush and an occupancy counter.
//
// Handshake: a word moves across a boundary exactly when the sender's valid and the
// receiver's ready are both high at a rising edge; ready never looks at valid.
module pipe_reg #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 2,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             flush,
    output logic [CW-1:0]    count
);

    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] rdy;
    logic [DEPTH-1:0] up_vld;
    logic [WIDTH-1:0] dat    [DEPTH];
    logic [WIDTH-1:0] up_dat [DEPTH];

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          in_acc;
    logic          out_acc;

    // A stage can take a word if it is empty or its own word moves on this cycle.
    always_comb begin
        rdy          = '0;
        rdy[DEPTH-1] = ~vld[DEPTH-1] | out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            rdy[i] = ~vld[i] | rdy[i+1];
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign up_vld[i] = in_valid & ~flush;
            assign up_dat[i] = in_data;
        end else begin : g_body
            assign up_vld[i] = vld[i-1];
            assign up_dat[i] = dat[i-1];
        end

        pipe_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk_i    (clk),
            .rst_ni   (rst),
            .flush_i  (flush),
            .up_vld_i (up_vld[i]),
            .up_dat_i (up_dat[i]),
            .rdy_i    (rdy[i]),
            .vld_o    (vld[i]),
            .dat_o    (dat[i])
        );
    end

    assign in_ready  = rdy[0] & ~flush;
    assign out_valid = vld[DEPTH-1];
    assign out_data  = dat[DEPTH-1];

    assign in_acc  = in_valid & in_ready;
    assign out_acc = out_valid & out_ready;

    // Occupancy cannot wrap: accepts are refused when full unless a word also leaves.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (in_acc && !out_acc) begin
            count_d = count_q + CW'(1);
        end else if (!in_acc && out_acc) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_pipe_reg.sv
// Bench for pipe_reg (WIDTH=6, DEPTH=2): directed scenarios plus a randomized
// out_ready/in_valid run against a queue model of in-order delivery with latency.
module tb_pipe_reg;

    localparam int WIDTH = 6;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             flush = 1'b0;
    logic [CW-1:0]    count;

    always #5 clk = ~clk;

    pipe_reg #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .flush     (flush),
        .count     (count)
    );

    // Model: words in flight in order; each word may reach the output no earlier than
    // DEPTH cycles after its accept and no earlier than the cycle after its
    // predecessor left.
    logic [WIDTH-1:0] exp_q[$];
    int               av_q[$];
    logic [WIDTH-1:0] m_last;
    int               cyc;
    int               n_acc;
    int               n_del;
    int               n_vec;
    int               n_err;

    function automatic bit m_ov();
        return exp_q.size() > 0 && av_q[0] <= cyc;
    endfunction

    function automatic bit m_ir();
        return !flush && !(exp_q.size() == DEPTH && !out_ready);
    endfunction

    function automatic logic [WIDTH-1:0] m_od();
        return m_ov() ? exp_q[0] : m_last;
    endfunction

    task automatic step();
        bit ov;
        bit acc;
        bit del;
        ov  = m_ov();
        acc = rst && in_valid && m_ir();
        del = rst && ov && out_ready;
        @(posedge clk);
        if (!rst) begin
            exp_q.delete();
            av_q.delete();
            m_last = '0;
        end else if (flush) begin
            if (ov) m_last = exp_q[0];
            if (del) n_del++;
            exp_q.delete();
            av_q.delete();
        end else begin
            if (del) begin
                m_last = exp_q.pop_front();
                void'(av_q.pop_front());
                n_del++;
                if (av_q.size() > 0 && av_q[0] < cyc + 1) av_q[0] = cyc + 1;
            end
            if (acc) begin
                exp_q.push_back(in_data);
                av_q.push_back(cyc + DEPTH);
                n_acc++;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_power_on();
        #3;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL por_out_valid got=%0b want=0", out_valid); end
        n_vec++; if (out_data !== '0) begin n_err++; $display("FAIL por_out_data got=%h want=00", out_data); end
        n_vec++; if (count !== '0) begin n_err++; $display("FAIL por_count got=%0d want=0", count); end
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_valid = (k < 3);
            in_data  = WIDTH'(k + 1);
            @(negedge clk);
            n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_in_ready k=%0d got=%0b want=1", k, in_ready); end
            n_vec++; if (out_valid !== (k >= 2 && k < 5)) begin n_err++; $display("FAIL stream_out_valid k=%0d got=%0b want=%0b", k, out_valid, (k >= 2 && k < 5)); end
            if (k >= 2 && k < 5) begin
                n_vec++; if (out_data !== WIDTH'(k - 1)) begin n_err++; $display("FAIL stream_out_data k=%0d got=%h want=%h", k, out_data, WIDTH'(k - 1)); end
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] got[$];
        logic [WIDTH-1:0] want [3];
        want[0] = 6'h0A; want[1] = 6'h0B; want[2] = 6'h0C;
        for (int k = 0; k < 10; k++) begin
            out_ready = (k >= 4);
            in_valid  = (k < 5);
            in_data   = (k == 0) ? 6'h0A : (k == 1) ? 6'h0B : 6'h0C;
            @(negedge clk);
            if (k == 2 || k == 3) begin
                n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready k=%0d got=%0b want=0", k, in_ready); end
                n_vec++; if (count !== CW'(2)) begin n_err++; $display("FAIL bp_count k=%0d got=%0d want=2", k, count); end
                n_vec++; if (out_valid !== 1'b1 || out_data !== 6'h0A) begin n_err++; $display("FAIL bp_hold k=%0d got=%0b/%h want=1/0a", k, out_valid, out_data); end
            end
            if (k == 4) begin
                n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_resume_ready got=%0b want=1", in_ready); end
            end
            if (out_valid === 1'b1 && out_ready) got.push_back(out_data);
            step();
        end
        n_vec++; if (got.size() != 3) begin n_err++; $display("FAIL bp_deliver_count got=%0d want=3", got.size()); end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            n_vec++; if (got[i] !== want[i]) begin n_err++; $display("FAIL bp_order i=%0d got=%h want=%h", i, got[i], want[i]); end
        end
    endtask

    task automatic test_full_pass();
        for (int k = 0; k < 7; k++) begin
            out_ready = (k >= 3);
            in_valid  = (k < 2) || (k == 3);
            in_data   = (k == 0) ? 6'h11 : (k == 1) ? 6'h12 : 6'h3F;
            @(negedge clk);
            if (k == 2) begin
                n_vec++; if (count !== CW'(2)) begin n_err++; $display("FAIL fp_full_count got=%0d want=2", count); end
            end
            if (k == 3) begin
                n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fp_in_ready got=%0b want=1", in_ready); end
                n_vec++; if (count !== CW'(2)) begin n_err++; $display("FAIL fp_count3 got=%0d want=2", count); end
            end
            if (k == 4) begin
                n_vec++; if (count !== CW'(2)) begin n_err++; $display("FAIL fp_count4 got=%0d want=2", count); end
                n_vec++; if (out_data !== 6'h12) begin n_err++; $display("FAIL fp_second got=%h want=12", out_data); end
            end
            if (k == 5) begin
                n_vec++; if (out_valid !== 1'b1 || out_data !== 6'h3F) begin n_err++; $display("FAIL fp_pass got=%0b/%h want=1/3f", out_valid, out_data); end
                n_vec++; if (count !== CW'(1)) begin n_err++; $display("FAIL fp_count5 got=%0d want=1", count); end
            end
            step();
        end
    endtask

    task automatic test_flush();
        for (int k = 0; k < 8; k++) begin
            out_ready = (k >= 3);
            flush     = (k == 2);
            in_valid  = (k < 3);
            in_data   = (k == 0) ? 6'h21 : (k == 1) ? 6'h22 : 6'h15;
            @(negedge clk);
            if (k == 2) begin
                n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_in_ready got=%0b want=0", in_ready); end
            end
            if (k == 3) begin
                n_vec++; if (count !== '0) begin n_err++; $display("FAIL flush_count got=%0d want=0", count); end
                n_vec++; if (out_data !== 6'h21) begin n_err++; $display("FAIL flush_data_kept got=%h want=21", out_data); end
            end
            if (k >= 3) begin
                n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_out_valid k=%0d got=%0b want=0", k, out_valid); end
            end
            step();
        end
        flush = 1'b0;
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = (k < 2);
            in_data  = (k == 0) ? 6'h31 : 6'h32;
            @(negedge clk);
            if (k == 2) begin
                n_vec++; if (count !== CW'(2)) begin n_err++; $display("FAIL rst_pre_count got=%0d want=2", count); end
            end
            step();
        end
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got=%0b want=0", out_valid); end
        n_vec++; if (out_data !== '0) begin n_err++; $display("FAIL rst_out_data got=%h want=00", out_data); end
        n_vec++; if (count !== '0) begin n_err++; $display("FAIL rst_count got=%0d want=0", count); end
        step();
        rst = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid = (k == 0);
            in_data  = 6'h33;
            @(negedge clk);
            n_vec++; if (out_valid !== (k == 2)) begin n_err++; $display("FAIL rst_after_valid k=%0d got=%0b want=%0b", k, out_valid, (k == 2)); end
            n_vec++; if (count !== CW'((k == 1 || k == 2) ? 1 : 0)) begin n_err++; $display("FAIL rst_after_count k=%0d got=%0d", k, count); end
            if (k == 2) begin
                n_vec++; if (out_data !== 6'h33) begin n_err++; $display("FAIL rst_after_data got=%h want=33", out_data); end
            end
            step();
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 1000; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = WIDTH'($urandom_range(0, 63));
            out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            n_vec++; if (out_valid !== m_ov()) begin n_err++; $display("FAIL rnd_out_valid k=%0d got=%0b want=%0b", k, out_valid, m_ov()); end
            n_vec++; if (out_data !== m_od()) begin n_err++; $display("FAIL rnd_out_data k=%0d got=%h want=%h", k, out_data, m_od()); end
            n_vec++; if (in_ready !== m_ir()) begin n_err++; $display("FAIL rnd_in_ready k=%0d got=%0b want=%0b", k, in_ready, m_ir()); end
            n_vec++; if (int'(count) != n_acc - n_del || int'(count) != exp_q.size()) begin n_err++; $display("FAIL rnd_count k=%0d got=%0d want=%0d", k, count, n_acc - n_del); end
            step();
        end
        idle(DEPTH + 2);
        n_vec++; if (n_acc != n_del || count !== '0) begin n_err++; $display("FAIL rnd_drain got=%0d/%0d want=%0d/0", n_del, count, n_acc); end
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        cyc    = 0;
        n_acc  = 0;
        n_del  = 0;
        m_last = '0;
        test_power_on();
        test_stream();
        idle(3);
        test_backpressure();
        idle(3);
        test_full_pass();
        idle(3);
        test_flush();
        idle(3);
        test_reset_midstream();
        idle(3);
        n_acc = 0;
        n_del = 0;
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
